// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding, FSM states and opcode predicates.
// Used by alu_exec_seq, alu_shifter and the ALU control decoder.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_SLT  = 4'b0010,
        OP_SLTU = 4'b0011,
        OP_SRL  = 4'b0100,
        OP_SLL  = 4'b0101,
        OP_SRA  = 4'b0110,
        OP_XOR  = 4'b1000,
        OP_OR   = 4'b1001,
        OP_AND  = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    function automatic logic is_shift(logic [3:0] op);
        return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
    endfunction

    function automatic logic is_illegal(logic [3:0] op);
        return (op == 4'b0111) || (op >= 4'b1011);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shift datapath: one bit per cycle, or a single-cycle barrel shifter
// when ALU_FAST_SHIFT_EN is defined (then done_o is constantly high).
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [SW-1:0]    amt_i,
    output logic             done_o,
    output logic [WIDTH-1:0] res_o
);

`ifdef ALU_FAST_SHIFT_EN

    logic unused_ok;

    // Barrel shift straight from the request operands
    always_comb begin
        unused_ok = clk_i ^ rst_i ^ start_i;
        done_o    = 1'b1;
        unique case (op_i)
            OP_SLL:  res_o = a_i << amt_i;
            OP_SRA:  res_o = WIDTH'($signed(a_i) >>> amt_i);
            default: res_o = a_i >> amt_i;
        endcase
    end

`else

    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_d;
    logic [SW-1:0]    cnt_q;
    logic [3:0]       op_q;

    // One-position step of the working register; res_o is the value after the final step
    always_comb begin
        unique case (op_q)
            OP_SLL:  work_d = {work_q[WIDTH-2:0], 1'b0};
            OP_SRA:  work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: work_d = {1'b0, work_q[WIDTH-1:1]};
        endcase
        done_o = (cnt_q == SW'(1));
        res_o  = work_d;
    end

    // Load on start, then shift and count down until the counter empties
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            work_q <= '0;
            cnt_q  <= '0;
            op_q   <= '0;
        end else if (start_i) begin
            work_q <= a_i;
            cnt_q  <= amt_i;
            op_q   <= op_i;
        end else if (cnt_q != '0) begin
            work_q <= work_d;
            cnt_q  <= cnt_q - SW'(1);
        end
    end

`endif

endmodule

// File: rtl/alu_exec_seq.sv
// Sequential execute unit with valid/ready request and result handshakes.
// Define ALU_FAST_SHIFT_EN for single-cycle barrel shifts.
module alu_exec_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_opcode,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_illegal
);

    localparam int SW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] shift_res;
    logic [SW-1:0]    amt;
    logic             shift_start;
    logic             shift_done;

    assign amt = i_operand_b[SW-1:0];

    alu_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk_i   (i_clk),
        .rst_i   (i_reset),
        .start_i (shift_start),
        .op_i    (i_opcode),
        .a_i     (i_operand_a),
        .amt_i   (amt),
        .done_o  (shift_done),
        .res_o   (shift_res)
    );

    // Single-cycle result for the request currently offered
    always_comb begin
        alu_res = '0;
        unique case (i_opcode)
            OP_ADD:  alu_res = i_operand_a + i_operand_b;
            OP_SUB:  alu_res = i_operand_a - i_operand_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                $signed(i_operand_a) < $signed(i_operand_b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, i_operand_a < i_operand_b};
            OP_XOR:  alu_res = i_operand_a ^ i_operand_b;
            OP_OR:   alu_res = i_operand_a | i_operand_b;
            OP_AND:  alu_res = i_operand_a & i_operand_b;
`ifdef ALU_FAST_SHIFT_EN
            OP_SRL, OP_SLL, OP_SRA: alu_res = shift_res;
`else
            OP_SRL, OP_SLL, OP_SRA: alu_res = i_operand_a;
`endif
            default: alu_res = '0;
        endcase
    end

    // Next-state and result capture for IDLE -> (SHIFT) -> DONE
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        illegal_d   = illegal_q;
        shift_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
`ifndef ALU_FAST_SHIFT_EN
                    if (is_shift(i_opcode) && (amt != '0)) begin
                        shift_start = 1'b1;
                        state_d     = ST_SHIFT;
                    end else
`endif
                    begin
                        result_d  = alu_res;
                        illegal_d = is_illegal(i_opcode);
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    result_d  = shift_res;
                    illegal_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and held result registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign o_ready   = (state_q == ST_IDLE);
    assign o_valid   = (state_q == ST_DONE);
    assign o_result  = result_q;
    assign o_illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq against a behavioural model.
// Honours ALU_FAST_SHIFT_EN for the expected latency of shifts.
module tb_alu_exec_seq;

    logic        i_clk;
    logic        i_reset;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_opcode;
    logic [31:0] i_operand_a;
    logic [31:0] i_operand_b;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_illegal;

    int vectors = 0;
    int miscompares = 0;

    alu_exec_seq #(.WIDTH(32)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_opcode    (i_opcode),
        .i_operand_a (i_operand_a),
        .i_operand_b (i_operand_b),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_illegal   (o_illegal)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] ref_res(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd3:    return (a < b) ? 32'd1 : 32'd0;
            4'd4:    return a >> sh;
            4'd5:    return a << sh;
            4'd6:    return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd8:    return a ^ b;
            4'd9:    return a | b;
            4'd10:   return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_ill(logic [3:0] op);
        return (op == 4'd7) || (op >= 4'd11);
    endfunction

    function automatic int ref_lat(logic [3:0] op, logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
        return (op == 4'd15 && b == 0) ? 1 : 1;
`else
        if (op >= 4'd4 && op <= 4'd6 && (b % 32) != 0)
            return int'(b % 32) + 1;
        return 1;
`endif
    endfunction

    // Issue one request, wait for its result, then complete the handshake
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic ill, output int lat);
        @(negedge i_clk);
        i_valid     = 1'b1;
        i_opcode    = op;
        i_operand_a = a;
        i_operand_b = b;
        i_ready     = 1'b0;
        @(posedge i_clk);
        #1;
        i_valid     = 1'b0;
        i_opcode    = 4'($urandom);
        i_operand_a = $urandom;
        i_operand_b = $urandom;
        lat = 1;
        while (!o_valid && lat < 100) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
        res = o_result;
        ill = o_illegal;
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_opcode = '0;
        i_operand_a = '0;
        i_operand_b = '0;
        repeat (2) @(posedge i_clk);
        #1;
        vectors++;
        if ({o_ready, o_valid, o_result, o_illegal} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_vals got rdy=%b vld=%b res=%h ill=%b want 1 0 0 0",
                     o_ready, o_valid, o_result, o_illegal);
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;
        vectors++;
        if ({o_ready, o_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_release got rdy=%b vld=%b want 1 0", o_ready, o_valid);
        end
    endtask

    // Directed cases with result, illegal flag and latency checked
    task automatic test_directed;
        logic [3:0]  ops[11]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd6, 4'd4, 4'd5, 4'd15, 4'd7, 4'd5};
        logic [31:0] as[11]   = '{32'hFFFFFFFF, 32'd0, 32'h80000000, 32'h80000000, 32'd77,
                                  32'h80000000, 32'h80000000, 32'd1, 32'h1234, 32'h55, 32'h3};
        logic [31:0] bs[11]   = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd77,
                                  32'h1F, 32'h1F, 32'h20, 32'h5678, 32'h66, 32'h1};
        logic [31:0] res;
        logic        ill;
        int          lat;
        for (int i = 0; i < 11; i++) begin
            run_op(ops[i], as[i], bs[i], res, ill, lat);
            vectors++;
            if (res !== ref_res(ops[i], as[i], bs[i]) || ill !== ref_ill(ops[i])) begin
                miscompares++;
                $display("FAIL directed_%0d op=%h got res=%h ill=%b want res=%h ill=%b",
                         i, ops[i], res, ill, ref_res(ops[i], as[i], bs[i]), ref_ill(ops[i]));
            end
            vectors++;
            if (lat !== ref_lat(ops[i], bs[i])) begin
                miscompares++;
                $display("FAIL directed_lat_%0d op=%h got %0d want %0d",
                         i, ops[i], lat, ref_lat(ops[i], bs[i]));
            end
        end
    endtask

    // Result held under backpressure; a request offered meanwhile is ignored
    task automatic test_backpressure;
        int n;
        @(negedge i_clk);
        i_valid = 1'b1;
        i_opcode = 4'd10;
        i_operand_a = 32'hF0F0;
        i_operand_b = 32'hFF00;
        @(posedge i_clk);
        #1;
        i_opcode = 4'd0;
        i_operand_a = 32'd1;
        i_operand_b = 32'd1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== 32'h0000F000) n++;
            @(posedge i_clk);
            #1;
        end
        vectors++;
        if (n != 0) begin
            miscompares++;
            $display("FAIL backpressure_hold bad cycles got %0d want 0 (res=%h)", n, o_result);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        vectors++;
        if ({o_valid, o_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL backpressure_release got vld=%b rdy=%b want 0 1", o_valid, o_ready);
        end
        @(posedge i_clk);
        #1;
        vectors++;
        if (o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure_no_accept got vld=%b want 0", o_valid);
        end
    endtask

    task automatic test_reset_mid_shift;
        logic [31:0] res;
        logic        ill;
        int          lat;
        @(negedge i_clk);
        i_valid = 1'b1;
        i_opcode = 4'd5;
        i_operand_a = 32'h1;
        i_operand_b = 32'd20;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        vectors++;
        if ({o_valid, o_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_mid_shift got vld=%b rdy=%b want 0 1", o_valid, o_ready);
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        run_op(4'd0, 32'd3, 32'd4, res, ill, lat);
        vectors++;
        if (res !== 32'd7 || lat !== 1) begin
            miscompares++;
            $display("FAIL post_reset_add got res=%h lat=%0d want 7 lat=1", res, lat);
        end
    endtask

    // Back-to-back requests: next one offered as soon as o_ready returns
    task automatic test_back_to_back;
        logic [31:0] res;
        logic        ill;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (o_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_ready_%0d got %b want 1", i, o_ready);
            end
            run_op(4'd8, 32'(i * 3), 32'hA5A5, res, ill, lat);
            vectors++;
            if (res !== (32'(i * 3) ^ 32'hA5A5) || lat !== 1) begin
                miscompares++;
                $display("FAIL b2b_%0d got res=%h lat=%0d want %h lat=1",
                         i, res, lat, 32'(i * 3) ^ 32'hA5A5);
            end
        end
    endtask

    task automatic test_random;
        logic [3:0]  op;
        logic [31:0] a, b, res;
        logic        ill;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if (($urandom & 3) == 0) b = a;
            run_op(op, a, b, res, ill, lat);
            vectors++;
            if (res !== ref_res(op, a, b) || ill !== ref_ill(op) || lat !== ref_lat(op, b)) begin
                miscompares++;
                $display("FAIL random_%0d op=%h a=%h b=%h got res=%h ill=%b lat=%0d want res=%h ill=%b lat=%0d",
                         i, op, a, b, res, ill, lat, ref_res(op, a, b), ref_ill(op), ref_lat(op, b));
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_backpressure;
        test_reset_mid_shift;
        test_back_to_back;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_exec_seq.md
# alu_exec_seq

Sequential integer execute unit that consumes the 4-bit ALU opcode produced by the ALU control decoder, together with two WIDTH-bit operands, and returns the result over a valid/ready handshake. It sits in the execute stage between operand selection and writeback. Logic, arithmetic and compare operations complete in one cycle; shifts run iteratively, one bit position per cycle, unless the fast-shift option is compiled in.

## Interface
- WIDTH, 32, operand/result width; must be a power of two, at least 8.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  reset, asynchronous and active-high.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request.
- i_opcode  in  4  ALU opcode.
- i_operand_a  in  WIDTH  operand A (shift source).
- i_operand_b  in  WIDTH  operand B (shift amount in low log2(WIDTH) bits).
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_result  out  WIDTH  result.
- o_illegal  out  1  opcode was undefined; qualified by o_valid.

## Operation
- Opcode map: 0000 ADD, 0001 SUB, 0010 SLT, 0011 SLTU, 0100 SRL, 0101 SLL, 0110 SRA, 1000 XOR, 1001 OR, 1010 AND.
- Codes 0111 and 1011–1111 are illegal: o_result = 0, o_illegal = 1, single-cycle path.
- ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
- SLT is a signed compare and SLTU an unsigned compare. Both return 1 or 0, zero-extended to WIDTH.
- Shift amount is i_operand_b[log2(WIDTH)-1:0]; upper bits are ignored. SRA fills with operand A's MSB; SRL and SLL fill with 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: o_ready = 1. On i_valid && o_ready, latch the opcode and operands.
  - Shift opcode with nonzero amount: go to SHIFT and load the counter with the amount.
  - Any other opcode, or a shift by 0: compute the result and go to DONE.
- SHIFT: shift the working register one position per cycle and decrement the counter. Leave for DONE in the cycle the counter reaches 1.
- DONE: o_valid = 1, and o_result/o_illegal are held stable. Return to IDLE on i_ready.
- o_ready is 0 in SHIFT and DONE. A request offered then is not accepted and must stay asserted by the producer.

## Timing
- Reset values: o_ready = 1, o_valid = 0, o_result = 0, o_illegal = 0; state IDLE; counter 0.
- Non-shift op or shift by 0: accepted at edge N, o_valid high after edge N. Latency 1 cycle.
- Shift by k (1 ≤ k ≤ WIDTH-1): o_valid high after edge N+k. Latency k+1 cycles.
- Handshake completes on the edge where o_valid && i_ready. o_ready rises after that edge, so a new request is accepted no earlier than the following edge. Back-to-back throughput is therefore one result per 2 cycles minimum.
- i_ready held high while in DONE: one cycle of o_valid, then IDLE.
- Inputs change while busy: no effect; operands are latched at acceptance.
- Reset asserted mid-shift or in DONE: immediately return to reset values. The pending result is discarded.
- o_result keeps its last value in IDLE. Consumers sample it only when o_valid is high.

## Configuration
- ALU_FAST_SHIFT_EN defined:
  - Shifts use a single-cycle barrel shifter.
  - Every opcode has latency 1.
  - The SHIFT state and counter are not synthesised.
- ALU_FAST_SHIFT_EN undefined: iterative shifting as described under Operation.
- Results are bit-identical in both modes; only latency differs.

## Structure
- Package alu_pkg holds:
  - the alu_op_e enum with the 4-bit encodings above;
  - the FSM state enum;
  - an is_shift(op) function returning true for SRL/SLL/SRA;
  - the illegal-opcode predicate.
- The alu control decoder imports the same alu_op_e, so producer and consumer share one encoding.
- Sub-module alu_shifter contains the shift datapath: the iterative register and counter, or the barrel shifter under ALU_FAST_SHIFT_EN. It exposes start/done/result.

## Test plan
- Reset mid-shift: SLL with b=20, reset asserted 5 cycles in → o_valid = 0 and o_ready = 1 immediately; a following ADD 3+4 returns 7 normally.
- ADD/SUB wrap: ADD 0xFFFFFFFF+1 → 0x00000000, 1-cycle latency; SUB 0−1 → 0xFFFFFFFF.
- Compares: SLT a=0x80000000, b=1 → 1; SLTU with the same operands → 0; SLT with equal operands → 0.
- Shifts without the macro:
  - SRA a=0x80000000, b=0x1F → 0xFFFFFFFF; o_valid appears 32 cycles after accept.
  - SRL with the same operands → 0x00000001.
  - SLL a=1, b=0x20 (amount 0) → 1 after 1 cycle.
- Backpressure: DIV-free AND 0xF0F0&0xFF00 → 0xF000 with i_ready held low 10 cycles. o_valid and o_result must stay stable, o_ready must stay 0, and a request offered during those cycles is not accepted.
- Illegal and fast-shift:
  - Opcode 1111 → o_result 0, o_illegal 1.
  - Rebuilt with ALU_FAST_SHIFT_EN: SRA 0x80000000 by 31 → 0xFFFFFFFF in 1 cycle.
